// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b/LC-3X word, ALU opcode and mul/div pipeline depth
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra,
        alu_sub,
        alu_or,
        alu_xor,
        alu_mul,
        alu_div
    } lc3b_aluop;

    localparam int lc3b_muldiv_latency = 3;

    function automatic logic is_multicycle(input lc3b_aluop op);
        return (op == alu_mul) || (op == alu_div);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: holds ALU operands stable for the op latency and hands the result downstream
module alu_sequencer
    import lc3b_types::*;
#(
    parameter int MULDIV_LATENCY = lc3b_muldiv_latency
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    input  logic      in_valid,
    output logic      in_ready,
    input  lc3b_aluop in_aluop,
    input  lc3b_word  in_a,
    input  lc3b_word  in_b,
    output lc3b_aluop alu_aluop,
    output lc3b_word  alu_a,
    output lc3b_word  alu_b,
    input  lc3b_word  alu_f,
    output logic      out_valid,
    input  logic      out_ready,
    output lc3b_word  out_f,
    output logic      busy
);

    localparam int CW = (MULDIV_LATENCY > 0) ? $clog2(MULDIV_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    lc3b_aluop       r_aluop;
    lc3b_word        r_a;
    lc3b_word        r_b;
    lc3b_word        r_f;
    logic            r_out_valid;
    logic            w_accept;

    assign in_ready  = !flush && (r_state == IDLE || (r_state == DONE && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign alu_aluop = r_aluop;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign out_f     = r_f;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == EXEC);

    // Accept loads the ALU inputs; EXEC counts down the mul/div pipeline, then captures f
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_aluop     <= alu_pass;
            r_a         <= '0;
            r_b         <= '0;
            r_f         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_state     <= EXEC;
            r_aluop     <= in_aluop;
            r_a         <= in_a;
            r_b         <= in_b;
            r_count     <= is_multicycle(in_aluop) ? CW'(MULDIV_LATENCY) : '0;
            r_out_valid <= 1'b0;
        end else if (r_state == DONE && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else if (r_state == EXEC) begin
            if (r_count != '0) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_f         <= alu_f;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors plus hand-written handshake, flush and reset sequences
module tb_alu_sequencer;
    import lc3b_types::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      flush = 1'b0;
    logic      in_valid = 1'b0;
    logic      out_ready = 1'b0;
    lc3b_aluop in_aluop = alu_pass;
    lc3b_word  in_a = '0;
    lc3b_word  in_b = '0;
    logic      in_ready;
    lc3b_aluop alu_aluop;
    lc3b_word  alu_a;
    lc3b_word  alu_b;
    lc3b_word  alu_f;
    logic      out_valid;
    lc3b_word  out_f;
    logic      busy;

    int n_pass = 0;
    int n_tot  = 0;

    alu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_aluop (in_aluop),
        .in_a     (in_a),
        .in_b     (in_b),
        .alu_aluop(alu_aluop),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_f    (alu_f),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_f    (out_f),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ALU stand-in: combinational single-cycle ops, mul/div through a 3-deep pipeline
    lc3b_word md;
    lc3b_word f_comb;
    lc3b_word md_pipe [3];

    always_comb begin
        md = (alu_aluop == alu_mul) ? alu_a * alu_b : ((alu_b != 16'h0) ? alu_a / alu_b : 16'hFFFF);
        case (alu_aluop)
            alu_add:  f_comb = alu_a + alu_b;
            alu_and:  f_comb = alu_a & alu_b;
            alu_not:  f_comb = ~alu_a;
            alu_pass: f_comb = alu_a;
            alu_sll:  f_comb = alu_a << alu_b[3:0];
            alu_srl:  f_comb = alu_a >> alu_b[3:0];
            alu_sra:  f_comb = lc3b_word'($signed(alu_a) >>> alu_b[3:0]);
            alu_sub:  f_comb = alu_a - alu_b;
            alu_or:   f_comb = alu_a | alu_b;
            alu_xor:  f_comb = alu_a ^ alu_b;
            default:  f_comb = 16'hDEAD;
        endcase
        alu_f = is_multicycle(alu_aluop) ? md_pipe[2] : f_comb;
    end

    always @(posedge clk) begin
        md_pipe[0] <= md;
        md_pipe[1] <= md_pipe[0];
        md_pipe[2] <= md_pipe[1];
    end

    typedef struct {
        string     nm;
        lc3b_aluop op;
        lc3b_word  a;
        lc3b_word  b;
        lc3b_word  f;
        int        lat;
        int        hold;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        bit ok;
        in_aluop = v.op;
        in_a = v.a;
        in_b = v.b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk({v.nm, " ready"}, {15'b0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        chk({v.nm, " alu_a"}, alu_a, v.a);
        chk({v.nm, " alu_b"}, alu_b, v.b);
        chk({v.nm, " alu_op"}, {12'b0, alu_aluop}, {12'b0, v.op});
        n = 0;
        ok = 1'b1;
        while (!out_valid && n < 20) begin
            ok &= busy && alu_a == v.a && alu_b == v.b && !in_ready;
            step();
            n++;
        end
        chk({v.nm, " latency"}, 16'(n), 16'(v.lat));
        chk({v.nm, " exec stable"}, {15'b0, ok}, 16'd1);
        chk({v.nm, " out_f"}, out_f, v.f);
        ok = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            step();
            ok &= out_valid && out_f == v.f && !in_ready && !busy;
        end
        if (v.hold > 0) chk({v.nm, " hold"}, {15'b0, ok}, 16'd1);
        out_ready = 1'b1;
        #1;
        chk({v.nm, " ready w/ out_ready"}, {15'b0, in_ready}, 16'd1);
        step();
        out_ready = 1'b0;
        #1;
        chk({v.nm, " drained"}, {15'b0, out_valid}, 16'd0);
    endtask

    initial begin
        bit ok;
        vecs[0]  = '{"add",  alu_add,  16'h0003, 16'h0004, 16'h0007, 1, 0};
        vecs[1]  = '{"and",  alu_and,  16'hF0F0, 16'hFF00, 16'hF000, 1, 0};
        vecs[2]  = '{"not",  alu_not,  16'h1234, 16'h0000, 16'hEDCB, 1, 0};
        vecs[3]  = '{"pass", alu_pass, 16'h5A5A, 16'h1111, 16'h5A5A, 1, 0};
        vecs[4]  = '{"sll",  alu_sll,  16'h0001, 16'h0004, 16'h0010, 1, 0};
        vecs[5]  = '{"srl",  alu_srl,  16'h8000, 16'h0003, 16'h1000, 1, 0};
        vecs[6]  = '{"sra",  alu_sra,  16'h8000, 16'h0001, 16'hC000, 1, 0};
        vecs[7]  = '{"or",   alu_or,   16'h00F0, 16'h0F00, 16'h0FF0, 1, 0};
        vecs[8]  = '{"mul",  alu_mul,  16'h0006, 16'h0007, 16'h002A, 4, 0};
        vecs[9]  = '{"div",  alu_div,  16'h0064, 16'h0007, 16'h000E, 4, 5};
        vecs[10] = '{"unk",  lc3b_aluop'(4'hF), 16'h0001, 16'h0002, 16'hDEAD, 1, 2};
        vecs[11] = '{"mul2", alu_mul,  16'h0100, 16'h0003, 16'h0300, 4, 1};

        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("rst out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst in_ready", {15'b0, in_ready}, 16'd1);
        chk("rst busy", {15'b0, busy}, 16'd0);
        chk("rst alu_op", {12'b0, alu_aluop}, {12'b0, alu_pass});
        chk("rst alu_a", alu_a, 16'h0000);
        chk("rst out_f", out_f, 16'h0000);

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // back-to-back: second accept shares the edge with the first completion
        in_aluop = alu_xor;
        in_a = 16'h00FF;
        in_b = 16'h0F0F;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b ready", {15'b0, in_ready}, 16'd1);
        step();
        in_aluop = alu_sub;
        in_a = 16'h0010;
        in_b = 16'h0001;
        #1;
        chk("b2b busy1", {15'b0, busy}, 16'd1);
        chk("b2b stall", {15'b0, in_ready}, 16'd0);
        step();
        chk("b2b valid1", {15'b0, out_valid}, 16'd1);
        chk("b2b f1", out_f, 16'h0FF0);
        chk("b2b ready1", {15'b0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        chk("b2b valid drop", {15'b0, out_valid}, 16'd0);
        chk("b2b busy2", {15'b0, busy}, 16'd1);
        chk("b2b alu_a2", alu_a, 16'h0010);
        chk("b2b alu_op2", {12'b0, alu_aluop}, {12'b0, alu_sub});
        step();
        chk("b2b valid2", {15'b0, out_valid}, 16'd1);
        chk("b2b f2", out_f, 16'h000F);
        step();
        chk("b2b idle", {15'b0, out_valid}, 16'd0);
        out_ready = 1'b0;

        // flush during mul EXEC discards the result
        in_aluop = alu_mul;
        in_a = 16'h0003;
        in_b = 16'h0005;
        in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        #1;
        chk("flush in_ready", {15'b0, in_ready}, 16'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush out_valid", {15'b0, out_valid}, 16'd0);
        chk("flush busy", {15'b0, busy}, 16'd0);
        chk("flush in_ready after", {15'b0, in_ready}, 16'd1);
        chk("flush alu_op", {12'b0, alu_aluop}, {12'b0, alu_pass});
        chk("flush out_f", out_f, 16'h0000);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            ok &= !out_valid && !busy;
        end
        chk("flush no pulse", {15'b0, ok}, 16'd1);
        run_op('{"post-flush add", alu_add, 16'h0001, 16'h0001, 16'h0002, 1, 0});

        // reset while a result is held in DONE
        in_aluop = alu_add;
        in_a = 16'h0002;
        in_b = 16'h0002;
        in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre-rst valid", {15'b0, out_valid}, 16'd1);
        chk("pre-rst f", out_f, 16'h0004);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid rst out_valid", {15'b0, out_valid}, 16'd0);
        chk("mid rst out_f", out_f, 16'h0000);
        chk("mid rst in_ready", {15'b0, in_ready}, 16'd1);
        chk("mid rst alu_op", {12'b0, alu_aluop}, {12'b0, alu_pass});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execute-stage front end that sits directly upstream of the LC-3b/LC-3X ALU.
- Accepts one operation at a time from the decode/EX pipeline register using a valid/ready handshake, and registers the operands and aluop that drive the ALU.
- Holds those ALU inputs stable for the pipelined multiplier/divider latency, captures f into a result register, and presents it downstream with valid/ready.
- Upstream is stalled, by deasserting in_ready, while a multi-cycle op is in flight.

Parameters:
- MULDIV_LATENCY, 3, number of clock edges between the ALU sampling stable a/b and f reflecting mul/div results. Must equal the ALU's lpm_pipeline depth.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight or held operation.
- in_valid  input  1  upstream has an operation.
- in_ready  output  1  sequencer can accept an operation this cycle.
- in_aluop  input  lc3b_aluop  requested operation.
- in_a  input  16  operand a (lc3b_word).
- in_b  input  16  operand b (lc3b_word).
- alu_aluop  output  lc3b_aluop  registered aluop to the ALU.
- alu_a  output  16  registered operand a to the ALU.
- alu_b  output  16  registered operand b to the ALU.
- alu_f  input  16  ALU result.
- out_valid  output  1  out_f holds a completed result.
- out_ready  input  1  downstream consumes the result.
- out_f  output  16  registered result.
- busy  output  1  high in EXEC; used by hazard logic.

Behaviour:
- Reset and flush:
  - State goes to IDLE; out_valid=0, busy=0, count=0.
  - alu_a, alu_b and out_f go to 16'h0000; alu_aluop goes to alu_pass.
  - reset has priority over flush; flush has priority over every handshake in the same cycle.
- States: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Forced to 0 when flush is high.
- Accept:
  - An accept occurs on an edge where in_valid && in_ready.
  - On accept, alu_aluop/alu_a/alu_b load the in_* values. State goes to EXEC.
  - count loads MULDIV_LATENCY if in_aluop is alu_mul or alu_div, otherwise 0.
- EXEC:
  - ALU inputs are held unchanged and busy=1.
  - If count!=0, count decrements.
  - If count==0, out_f is captured from alu_f, out_valid goes to 1, and state goes to DONE.
- Latency from the accept edge E to the capture edge:
  - Single-cycle ops (add, and, not, pass, sll, srl, sra, sub, or, xor): capture at E+1.
  - mul/div: capture at E+1+MULDIV_LATENCY, i.e. E+4 at the default.
  - Unknown aluop codes are treated as single-cycle.
- DONE:
  - out_valid=1 and out_f is held until out_ready.
  - If out_ready && !in_valid, out_valid goes to 0 and state goes to IDLE.
  - If out_ready && in_valid, the completion and the new accept happen on the same edge: out_valid goes to 0 and state goes to EXEC with the new operands. No bubble cycle beyond EXEC.
- Throughput: one single-cycle op per 2 clocks; one mul/div per MULDIV_LATENCY+2 clocks.
- While in DONE, the ALU inputs keep the last operands; alu_f is ignored.
- in_valid is ignored in EXEC; upstream must hold in_* until accepted.
- count width is $clog2(MULDIV_LATENCY+1). MULDIV_LATENCY=0 is legal and makes mul/div single-cycle.
- A flush during EXEC discards the pending result: no out_valid pulse and no out_f update.

Decomposition:
- lc3b_types already carries lc3b_word and lc3b_aluop. Add a shared constant lc3b_muldiv_latency (3) there.
- Add a helper function is_multicycle(lc3b_aluop) there too, so the ALU instance and the sequencer cannot diverge.
- Local enum for IDLE/EXEC/DONE.
- No sub-module. The ALU itself is instantiated alongside this block at the execute-stage level, not inside it.

Test Plan:
- add a=16'h0003 b=16'h0004, out_ready=1 -> out_valid high one cycle after the accept edge+1 with out_f=16'h0007; in_ready low for exactly 1 cycle.
- mul a=16'h0006 b=16'h0007 -> busy high for 4 cycles; out_f=16'h002A at E+4. alu_a/alu_b stay stable through all busy cycles.
- div a=16'h0064 b=16'h0007 with out_ready=0 for 5 cycles -> out_f=16'h000E held and out_valid held; in_ready=0 until out_ready rises.
- Back-to-back xor 16'h00FF^16'h0F0F then sub 16'h0010-16'h0001, in_valid held, out_ready=1 -> results 16'h0FF0 then 16'h000F; second accept coincides with the first completion edge.
- flush asserted at EXEC cycle 2 of a mul -> no out_valid pulse, state IDLE next cycle; the following add 1+1 returns 16'h0002 normally.
- reset asserted mid-DONE with out_valid=1 -> next cycle out_valid=0, out_f=0, in_ready=1, alu_aluop=alu_pass.
